layer_pad_ring: RTL and testbench

Parametrised pad-ring controller for one die layer of the 3D power benches. Conditions N_IN raw input-pad signals into the layer core through a synchroniser and glitch filter, and registers N_OUT core signals onto output pads. Adds a serial boundary chain (capture/shift/update) so inter-layer pads can be observed and forced from test. Sits between the IN_PAD/OUT_PAD cells and the layer core logic.

---
 rtl/layer_pad_pkg.sv | 23 ++
 rtl/layer_pad_ring_pad_in_filter.sv | 55 +++++
 rtl/layer_pad_ring.sv | 145 ++++++++++++++
 tb/tb_layer_pad_ring.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_pad_pkg.sv
// ---------------------------------------------------------------------------
// layer_pad_pkg
// Shared types for the layer pad-ring controller.
//   cmd_e   : boundary-chain command encoding carried on the 2-bit cmd port
//   state_e : boundary-chain sequencer states
// ---------------------------------------------------------------------------
package layer_pad_pkg;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'd0,
    CMD_CAPTURE = 2'd1,
    CMD_SHIFT   = 2'd2,
    CMD_UPDATE  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    SHIFT = 2'd2,
    UPD   = 2'd3
  } state_e;

endpackage

// File: rtl/layer_pad_ring_pad_in_filter.sv
// ---------------------------------------------------------------------------
// pad_in_filter
// One input-pad channel: a SYNC_STAGES-deep synchroniser followed by a
// glitch filter. The filtered value only moves once FILT_LEN consecutive
// synchronised samples disagree with it; any agreeing sample restarts the
// count, so short pulses never reach the core.
// Ports:
//   clk1     : clock, rising edge
//   rst      : synchronous active-high reset
//   raw      : asynchronous pad signal
//   filtered : conditioned level (registered)
// ---------------------------------------------------------------------------
module pad_in_filter
  import layer_pad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk1,
  input  logic rst,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   filt_reg;
  logic                   sample;

  assign sample   = sync_reg[SYNC_STAGES-1];
  assign filtered = filt_reg;

  always_ff @(posedge clk1) begin
    if (rst) begin
      sync_reg <= '0;
      cnt_reg  <= '0;
      filt_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
      if (sample == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        // This sample completes the run of disagreeing samples.
        filt_reg <= sample;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_pad_ring.sv
// ---------------------------------------------------------------------------
// layer_pad_ring
// Pad-ring controller for one die layer. Conditions input pads into the core,
// registers core outputs onto output pads, and provides a serial boundary
// chain (capture / shift / update) for observing and forcing pads.
// Chain order: chain[0..N_IN-1] = input channels, chain[N_IN..L-1] = outputs.
// Ports:
//   clk1, rst            : clock and synchronous active-high reset
//   pad_in  / core_in    : raw input pads / conditioned inputs to core
//   core_out / pad_out   : core signals / registered output-pad drive
//   test_mode            : 1 = core_in and pad_out sourced from update register
//   cmd_valid, cmd       : command request (NOP/CAPTURE/SHIFT/UPDATE)
//   cmd_ready, busy      : sequencer idle / occupied
//   sc_si, sc_so         : serial chain in / out (sc_so = chain[0])
// ---------------------------------------------------------------------------
module layer_pad_ring
  import layer_pad_pkg::*;
#(
  parameter int N_IN        = 5,
  parameter int N_OUT       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic [N_IN-1:0]  pad_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] pad_out,
  input  logic             test_mode,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  output logic             cmd_ready,
  input  logic             sc_si,
  output logic             sc_so,
  output logic             busy
);

  localparam int L  = N_IN + N_OUT;
  localparam int CW = $clog2(L);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  logic [N_IN-1:0]  filtered;
  logic [L-1:0]     chain_reg;
  logic [L-1:0]     upd_reg;
  logic [N_OUT-1:0] pad_out_reg;
  logic [CW-1:0]    shift_cnt_reg;
  state_e           state_reg;
  logic             ready_reg;
  logic             busy_reg;

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_in
      pad_in_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
      ) u_filter (
        .clk1    (clk1),
        .rst     (rst),
        .raw     (pad_in[gi]),
        .filtered(filtered[gi])
      );
    end
  endgenerate

  // Test override on core_in is a plain mux so test_mode acts immediately.
  assign core_in   = test_mode ? upd_reg[N_IN-1:0] : filtered;
  assign pad_out   = pad_out_reg;
  assign sc_so     = chain_reg[0];
  assign cmd_ready = ready_reg;
  assign busy      = busy_reg;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_cnt_reg <= '0;
      chain_reg     <= '0;
      upd_reg       <= '0;
      pad_out_reg   <= '0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      pad_out_reg <= test_mode ? upd_reg[L-1:N_IN] : core_out;

      case (state_reg)
        IDLE: begin
          // ready_reg is high whenever we are here, so cmd_valid alone accepts.
          if (cmd_valid) begin
            case (cmd_e'(cmd))
              CMD_CAPTURE: begin
                state_reg <= CAPT;
                ready_reg <= 1'b0;
                busy_reg  <= 1'b1;
              end
              CMD_SHIFT: begin
                state_reg     <= SHIFT;
                shift_cnt_reg <= '0;
                ready_reg     <= 1'b0;
                busy_reg      <= 1'b1;
              end
              CMD_UPDATE: begin
                state_reg <= UPD;
                ready_reg <= 1'b0;
                busy_reg  <= 1'b1;
              end
              default: begin
                state_reg <= IDLE;
              end
            endcase
          end
        end
        CAPT: begin
          chain_reg <= {core_out, filtered};
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
        SHIFT: begin
          // Shift toward chain[0]; sc_si enters at the output end.
          chain_reg <= {sc_si, chain_reg[L-1:1]};
          if (shift_cnt_reg == LAST) begin
            shift_cnt_reg <= '0;
            state_reg     <= IDLE;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
          end else begin
            shift_cnt_reg <= shift_cnt_reg + 1'b1;
          end
        end
        UPD: begin
          upd_reg   <= chain_reg;
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_pad_ring.sv
// ---------------------------------------------------------------------------
// tb_layer_pad_ring
// Scoreboard bench: a behavioural model runs on every rising edge and pushes
// the expected outputs into a queue; a monitor pops and compares them just
// after the edge. Directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_layer_pad_ring;
  import layer_pad_pkg::*;

  localparam int N_IN  = 5;
  localparam int N_OUT = 1;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int L     = N_IN + N_OUT;

  logic             clk1 = 1'b0;
  logic             rst;
  logic [N_IN-1:0]  pad_in;
  logic [N_IN-1:0]  core_in;
  logic [N_OUT-1:0] core_out;
  logic [N_OUT-1:0] pad_out;
  logic             test_mode;
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic             cmd_ready;
  logic             sc_si;
  logic             sc_so;
  logic             busy;

  always #5 clk1 = ~clk1;

  layer_pad_ring #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SYNC_STAGES(SYNC), .FILT_LEN(FILT)
  ) dut (
    .clk1(clk1), .rst(rst), .pad_in(pad_in), .core_in(core_in),
    .core_out(core_out), .pad_out(pad_out), .test_mode(test_mode),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .sc_si(sc_si), .sc_so(sc_so), .busy(busy)
  );

  typedef struct packed {
    logic [N_IN-1:0]  core_in;
    logic [N_OUT-1:0] pad_out;
    logic             sc_so;
    logic             cmd_ready;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;

  // ---------------- behavioural reference model ----------------
  // hist holds the last SYNC+FILT sampled pad_in words (oldest first). The
  // filter input at an edge is the word SYNC samples old, so the FILT-long
  // window feeding the filter decision is hist[0..FILT-1].
  logic [N_IN-1:0]  hist[$];
  logic [N_IN-1:0]  m_filt;
  logic [L-1:0]     m_chain;
  logic [L-1:0]     m_upd;
  logic [N_OUT-1:0] m_pad_out;
  int               m_pending;   // 0 idle, 1 capture, 2 shift, 3 update
  int               m_left;
  bit               m_accept;
  logic [N_IN-1:0]  cap_f;
  logic [L-1:0]     old_chain;
  logic [L-1:0]     old_upd;
  bit               all_diff;
  exp_t             e_new;

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC + FILT; k++) hist.push_back('0);
    m_filt    = '0;
    m_chain   = '0;
    m_upd     = '0;
    m_pad_out = '0;
    m_pending = 0;
    m_left    = 0;
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk1);
      cycle++;
      m_accept = 0;
      if (rst) begin
        model_reset();
      end else begin
        cap_f     = m_filt;
        old_chain = m_chain;
        old_upd   = m_upd;
        hist.push_back(pad_in);
        void'(hist.pop_front());
        for (int i = 0; i < N_IN; i++) begin
          all_diff = 1;
          for (int f = 0; f < FILT; f++)
            if (hist[f][i] == m_filt[i]) all_diff = 0;
          if (all_diff) m_filt[i] = ~m_filt[i];
        end
        m_pad_out = test_mode ? old_upd[L-1:N_IN] : core_out;
        case (m_pending)
          1: begin m_chain = {core_out, cap_f}; m_pending = 0; end
          2: begin
            m_chain = {sc_si, old_chain[L-1:1]};
            m_left--;
            if (m_left == 0) m_pending = 0;
          end
          3: begin m_upd = old_chain; m_pending = 0; end
          default: begin
            if (cmd_valid) begin
              m_accept = 1;
              if (cmd == 2'd1) m_pending = 1;
              else if (cmd == 2'd2) begin m_pending = 2; m_left = L; end
              else if (cmd == 2'd3) m_pending = 3;
            end
          end
        endcase
      end
      e_new.core_in   = test_mode ? m_upd[N_IN-1:0] : m_filt;
      e_new.pad_out   = m_pad_out;
      e_new.sc_so     = m_chain[0];
      e_new.cmd_ready = (m_pending == 0);
      e_new.busy      = (m_pending != 0);
      exp_q.push_back(e_new);
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk1);
      #1;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty cycle %0d: no expected entry", cycle);
      end else begin
        e = exp_q.pop_front();
        if (core_in !== e.core_in || pad_out !== e.pad_out || sc_so !== e.sc_so ||
            cmd_ready !== e.cmd_ready || busy !== e.busy) begin
          miscompares++;
          $display("FAIL outputs cycle %0d: got core_in=%b pad_out=%b sc_so=%b ready=%b busy=%b, expected core_in=%b pad_out=%b sc_so=%b ready=%b busy=%b",
                   cycle, core_in, pad_out, sc_so, cmd_ready, busy,
                   e.core_in, e.pad_out, e.sc_so, e.cmd_ready, e.busy);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Hold a command until the model reports acceptance; returns on the
  // falling edge after the accepting rising edge.
  task automatic issue_cmd(input logic [1:0] c);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd       = c;
    do begin
      @(negedge clk1);
      n++;
    end while (!m_accept && n < 40);
    cmd_valid = 1'b0;
    if (!m_accept) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: cmd %0d not accepted within %0d cycles", c, n);
    end else begin
      $display("cmd %0d accepted at cycle %0d", c, cycle);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [5:0] seq;
    logic [5:0] pat;
    int         busy_cnt;
    int         low_cnt;
    int         n;

    rst = 1'b1; pad_in = 5'h1F; core_out = 1'b1; test_mode = 1'b0;
    cmd_valid = 1'b0; cmd = 2'd0; sc_si = 1'b0;

    // Reset held for two edges with active inputs.
    @(negedge clk1);
    chk("reset_ready_during", {7'd0, cmd_ready}, 8'd1);
    chk("reset_core_in", {3'd0, core_in}, 8'd0);
    @(negedge clk1);
    chk("reset_pad_out", {7'd0, pad_out}, 8'd0);
    chk("reset_sc_so_busy", {6'd0, sc_so, busy}, 8'd0);
    rst = 1'b0; pad_in = '0; core_out = '0;
    @(negedge clk1);
    chk("reset_ready_after", {7'd0, cmd_ready}, 8'd1);

    // Filter: steady step on bit 0, two-cycle glitch on bit 1.
    pad_in = 5'b00011;
    repeat (2) @(negedge clk1);
    pad_in = 5'b00001;
    repeat (2) @(negedge clk1);
    chk("filter_step_edge4", {7'd0, core_in[0]}, 8'd0);
    @(negedge clk1);
    chk("filter_step_edge5", {7'd0, core_in[0]}, 8'd1);
    repeat (3) @(negedge clk1);
    chk("filter_glitch", {7'd0, core_in[1]}, 8'd0);

    // Capture then shift out.
    pad_in = 5'b10110; core_out = 1'b1;
    repeat (8) @(negedge clk1);
    issue_cmd(2'd1);
    issue_cmd(2'd2);
    busy_cnt = 0;
    for (int k = 0; k < L; k++) begin
      seq[k] = sc_so;
      if (busy) busy_cnt++;
      @(negedge clk1);
    end
    chk("shift_sequence", {2'd0, seq}, 8'b00110110);
    chk("shift_busy_cycles", 8'(busy_cnt), 8'd6);
    chk("shift_busy_end", {7'd0, busy}, 8'd0);

    // Force: shift a pattern in (bit 0 first so it lands in chain[0]).
    pat = 6'b100101;
    issue_cmd(2'd2);
    for (int k = 0; k < L; k++) begin
      sc_si = pat[k];
      @(negedge clk1);
    end
    sc_si = 1'b0;
    issue_cmd(2'd3);
    test_mode = 1'b1;
    @(negedge clk1);
    chk("force_core_in", {3'd0, core_in}, 8'b00000101);
    @(negedge clk1);
    chk("force_pad_out", {7'd0, pad_out}, 8'd1);
    test_mode = 1'b0;
    @(negedge clk1);
    chk("release_core_in", {3'd0, core_in}, 8'b00010110);

    // Handshake: UPDATE held during SHIFT waits for ready.
    issue_cmd(2'd2);
    cmd_valid = 1'b1; cmd = 2'd3;
    low_cnt = 0; n = 0;
    do begin
      if (!cmd_ready) low_cnt++;
      @(negedge clk1);
      n++;
    end while (!m_accept && n < 40);
    cmd_valid = 1'b0;
    chk("handshake_ready_low", 8'(low_cnt), 8'(L));
    $display("cmd 3 accepted at cycle %0d after wait", cycle);

    // Reset in the middle of a shift.
    repeat (2) @(negedge clk1);
    issue_cmd(2'd2);
    repeat (3) @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    chk("midshift_rst_sc_so", {7'd0, sc_so}, 8'd0);
    chk("midshift_rst_ready_busy", {6'd0, cmd_ready, busy}, 8'b10);
    pad_in = 5'b00001;
    repeat (8) @(negedge clk1);
    issue_cmd(2'd1);
    @(negedge clk1);
    chk("post_rst_capture", {7'd0, sc_so}, 8'd1);

    // Randomized traffic checked by the scoreboard.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_IN; i++)
        if ($urandom_range(3) == 0) pad_in[i] = ~pad_in[i];
      core_out  = N_OUT'($urandom);
      sc_si     = 1'($urandom);
      if ($urandom_range(15) == 0) test_mode = ~test_mode;
      cmd_valid = ($urandom_range(2) == 0);
      cmd       = 2'($urandom);
      rst       = ($urandom_range(199) == 0);
      @(negedge clk1);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
